// File: rtl/pc_trace_fifo_pkg.sv
// Shared constants for the PC write-back trace buffer: default sizing and
// the layout of one stored entry.
package pc_trace_fifo_pkg;

  localparam int unsigned DEPTH_DEF = 16;
  localparam int unsigned CW_DEF    = 16;
  localparam int unsigned ENTRY_W   = 64;
  localparam int unsigned PC_MSB    = 63;
  localparam int unsigned PC_LSB    = 32;
  localparam int unsigned DATA_MSB  = 31;
  localparam int unsigned DATA_LSB  = 0;

  function automatic logic [ENTRY_W-1:0] entry_pack(input logic [31:0] pc,
                                                    input logic [31:0] data);
    return {pc, data};
  endfunction

endpackage

// File: rtl/pc_trace_fifo_if.sv
// Read-side handshake of the trace buffer; master is the buffer, slave is
// the debug consumer.
interface pc_trace_fifo_if;

  logic        RdValid;
  logic        RdReady;
  logic [31:0] RdPC;
  logic [31:0] RdData;

  modport master (output RdValid, output RdPC, output RdData, input RdReady);
  modport slave  (input RdValid, input RdPC, input RdData, output RdReady);

endinterface

// File: rtl/trace_fifo_mem.sv
// First-word fall-through FIFO storage with wrap-bit pointers. Storage is
// deliberately left unreset; only the pointers carry state across reset.
module trace_fifo_mem
  import pc_trace_fifo_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               push,
  input  logic               pop,
  input  logic [ENTRY_W-1:0] wdata,
  output logic [ENTRY_W-1:0] rdata,
  output logic               empty,
  output logic               full,
  output logic [AW:0]        count
);

  logic [AW:0]        wr_ptr_q, wr_ptr_d;
  logic [AW:0]        rd_ptr_q, rd_ptr_d;
  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic               pop_ok;
  logic               wr_en;

  assign empty  = (wr_ptr_q == rd_ptr_q);
  assign full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count  = wr_ptr_q - rd_ptr_q;
  assign rdata  = mem_q[rd_ptr_q[AW-1:0]];
  assign pop_ok = pop && !empty && !clear;
  // When full, a same-cycle pop frees the very slot being written.
  assign wr_en  = push && !clear && (!full || pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (wr_en)  wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok) rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/pc_trace_fifo.sv
// Trace buffer top: records {PC, write-back data} whenever the fetch PC
// advances, skipping stall cycles, and counts captures lost while full.
module pc_trace_fifo
  import pc_trace_fifo_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned CW    = CW_DEF,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic                   Clk,
  input  logic                   Rst,
  input  logic                   Enable,
  input  logic                   Clear,
  input  logic [31:0]            PCIn,
  input  logic [31:0]            DataIn,
  pc_trace_fifo_if.master        rd,
  output logic [AW:0]            Count,
  output logic                   Full,
  output logic [CW-1:0]          DropCount
);

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + CW'(1);
  endfunction

  logic [31:0]        last_pc_q, last_pc_d;
  logic               primed_q, primed_d;
  logic [CW-1:0]      drop_q, drop_d;
  logic [ENTRY_W-1:0] rdata;
  logic               empty;
  logic               full;
  logic               cap;
  logic               pop;
  logic               drop;

  // The first enabled cycle after reset/clear always captures, so PC 0 is seen.
  assign cap  = Enable && (!primed_q || (PCIn != last_pc_q));
  assign pop  = !empty && rd.RdReady;
  assign drop = cap && full && !pop && !Clear;

  always_comb begin
    last_pc_d = last_pc_q;
    primed_d  = primed_q;
    drop_d    = drop_q;
    if (Clear) begin
      primed_d = 1'b0;
      drop_d   = '0;
    end else begin
      if (Enable) begin
        last_pc_d = PCIn;
        primed_d  = 1'b1;
      end
      if (drop) drop_d = sat_inc(drop_q);
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      last_pc_q <= '0;
      primed_q  <= 1'b0;
      drop_q    <= '0;
    end else begin
      last_pc_q <= last_pc_d;
      primed_q  <= primed_d;
      drop_q    <= drop_d;
    end
  end

  trace_fifo_mem #(.DEPTH(DEPTH)) u_mem (
    .clk   (Clk),
    .rst_n (Rst),
    .clear (Clear),
    .push  (cap),
    .pop   (pop),
    .wdata (entry_pack(PCIn, DataIn)),
    .rdata (rdata),
    .empty (empty),
    .full  (full),
    .count (Count)
  );

  assign rd.RdValid = !empty;
  assign rd.RdPC    = rdata[PC_MSB:PC_LSB];
  assign rd.RdData  = rdata[DATA_MSB:DATA_LSB];
  assign Full       = full;
  assign DropCount  = drop_q;

endmodule

// File: tb/tb_pc_trace_fifo.sv
// Directed bench for pc_trace_fifo: stimulus queues hand-computed entries,
// a negedge monitor checks every handshake transfer against that queue.
module tb_pc_trace_fifo;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        clr;
  logic [31:0] pc;
  logic [31:0] din;
  logic [4:0]  count;
  logic        full;
  logic [15:0] drop_cnt;

  int tests = 0;
  int fails = 0;
  logic [63:0] exp_q [$];

  pc_trace_fifo_if rd_if ();

  pc_trace_fifo #(.DEPTH(16), .CW(16)) dut (
    .Clk       (clk),
    .Rst       (rst_n),
    .Enable    (en),
    .Clear     (clr),
    .PCIn      (pc),
    .DataIn    (din),
    .rd        (rd_if),
    .Count     (count),
    .Full      (full),
    .DropCount (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, expv);
    end
  endtask

  // One clock of stimulus; exp says whether this cycle should store an entry.
  task automatic cyc(input logic [31:0] p, input logic [31:0] d,
                     input logic e, input logic r, input logic exp);
    pc = p;
    din = d;
    en = e;
    rd_if.RdReady = r;
    @(posedge clk);
    if (exp) exp_q.push_back({p, d});
    #1;
  endtask

  task automatic drain(input int n);
    for (int k = 0; k < n; k++) cyc(32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
  endtask

  always @(negedge clk) begin
    logic [63:0] e;
    if (rst_n) begin
      chk("rd_valid", {63'd0, rd_if.RdValid}, {63'd0, exp_q.size() != 0});
      if (rd_if.RdValid && rd_if.RdReady) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pop", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("rd_pc", {32'd0, rd_if.RdPC}, {32'd0, e[63:32]});
          chk("rd_data", {32'd0, rd_if.RdData}, {32'd0, e[31:0]});
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    en = 1'b0;
    clr = 1'b0;
    pc = '0;
    din = '0;
    rd_if.RdReady = 1'b0;

    // Reset priming
    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid", {63'd0, rd_if.RdValid}, 64'd0);
    chk("reset_count", {59'd0, count}, 64'd0);
    chk("reset_full", {63'd0, full}, 64'd0);
    chk("reset_drop", {48'd0, drop_cnt}, 64'd0);
    rst_n = 1'b1;
    cyc(32'h0, 32'h5, 1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) cyc(32'h0, 32'h5, 1'b1, 1'b0, 1'b0);
    chk("prime_count", {59'd0, count}, 64'd1);
    drain(2);
    chk("prime_drained", {59'd0, count}, 64'd0);

    // Stall filtering
    cyc(32'h4, 32'hA4, 1'b1, 1'b0, 1'b1);
    cyc(32'h8, 32'hA8, 1'b1, 1'b0, 1'b1);
    cyc(32'h8, 32'hB8, 1'b1, 1'b0, 1'b0);
    cyc(32'h8, 32'hC8, 1'b1, 1'b0, 1'b0);
    cyc(32'hC, 32'hAC, 1'b1, 1'b0, 1'b1);
    chk("stall_count", {59'd0, count}, 64'd3);
    drain(4);

    // Overflow: 20 PCs into 16 slots
    for (int i = 0; i < 20; i++)
      cyc(32'h100 + 32'(4 * i), 32'hD0 + 32'(i), 1'b1, 1'b0, i < 16);
    chk("ovf_full", {63'd0, full}, 64'd1);
    chk("ovf_count", {59'd0, count}, 64'd16);
    chk("ovf_drop", {48'd0, drop_cnt}, 64'd4);

    // Full with simultaneous push and pop
    cyc(32'h200, 32'hE0, 1'b1, 1'b1, 1'b1);
    chk("fpp_count", {59'd0, count}, 64'd16);
    chk("fpp_drop", {48'd0, drop_cnt}, 64'd4);
    chk("fpp_full", {63'd0, full}, 64'd1);
    drain(17);
    chk("fpp_drained", {59'd0, count}, 64'd0);
    chk("fpp_notfull", {63'd0, full}, 64'd0);

    // Clear mid-fill while the PC changes
    for (int i = 0; i < 5; i++)
      cyc(32'h300 + 32'(4 * i), 32'hF0 + 32'(i), 1'b1, 1'b0, 1'b1);
    chk("clr_fill_count", {59'd0, count}, 64'd5);
    clr = 1'b1;
    cyc(32'h400, 32'h44, 1'b1, 1'b0, 1'b0);
    clr = 1'b0;
    exp_q.delete();
    chk("clr_count", {59'd0, count}, 64'd0);
    chk("clr_drop", {48'd0, drop_cnt}, 64'd0);
    chk("clr_valid", {63'd0, rd_if.RdValid}, 64'd0);
    cyc(32'h400, 32'h45, 1'b1, 1'b0, 1'b1);
    chk("clr_recapture", {59'd0, count}, 64'd1);
    drain(2);

    // Asynchronous reset mid-drain
    for (int i = 0; i < 5; i++)
      cyc(32'h500 + 32'(4 * i), 32'h50 + 32'(i), 1'b1, 1'b0, 1'b1);
    cyc(32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    cyc(32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    chk("rst_pre_count", {59'd0, count}, 64'd3);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("rst_async_valid", {63'd0, rd_if.RdValid}, 64'd0);
    chk("rst_async_count", {59'd0, count}, 64'd0);
    chk("rst_async_full", {63'd0, full}, 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rd_if.RdReady = 1'b0;

    // Enable gating
    cyc(32'h10, 32'h61, 1'b1, 1'b0, 1'b1);
    drain(2);
    cyc(32'h14, 32'h62, 1'b0, 1'b0, 1'b0);
    cyc(32'h14, 32'h63, 1'b0, 1'b0, 1'b0);
    chk("gate_disabled_count", {59'd0, count}, 64'd0);
    cyc(32'h14, 32'h64, 1'b1, 1'b0, 1'b1);
    cyc(32'h14, 32'h65, 1'b1, 1'b0, 1'b0);
    chk("gate_count", {59'd0, count}, 64'd1);
    drain(2);

    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    chk("final_count", {59'd0, count}, 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pc_trace_fifo.md
# pc_trace_fifo

Write-back trace buffer sitting directly downstream of the pipelined MIPS core top level. Consumes the core's per-cycle `PCCheck`/`WriteDataCheck` observation outputs. Captures one `{PC, write-back data}` entry each time the fetch PC advances, so stall cycles are not recorded. Entries are buffered in a FIFO and drained by a debug consumer through a valid/ready handshake.

## Interface
Parameters:
- `DEPTH`, 16, number of FIFO entries; must be a power of two, ≥ 2.
- `CW`, 16, width of the drop counter.

Ports:
- `Clk`  in  1  — single clock; all state updates on the rising edge.
- `Rst`  in  1  — asynchronous, active-low reset.
- `Enable`  in  1  — capture enable; when low, no capture and no PC-history update.
- `Clear`  in  1  — synchronous flush of FIFO, drop counter and priming.
- `PCIn`  in  32  — driven from the core's `PCCheck`.
- `DataIn`  in  32  — driven from the core's `WriteDataCheck`.
- `RdReady`  in  1  — consumer accepts the head entry.
- `RdValid`  out  1  — head entry present (FIFO not empty).
- `RdPC`  out  32  — PC field of the head entry.
- `RdData`  out  32  — data field of the head entry.
- `Count`  out  log2(DEPTH)+1  — current occupancy.
- `Full`  out  1  — `Count == DEPTH`.
- `DropCount`  out  CW  — saturating count of captures lost while full.

## Operation
- State:
  - `LastPC` [31:0]
  - `Primed`
  - write/read pointers, each log2(DEPTH)+1 bits (MSB = wrap bit)
  - storage of DEPTH × 64 bits
  - `DropCount`
- Capture request `cap` = `Enable && (!Primed || PCIn != LastPC)`.
- Every cycle with `Enable` high:
  - `LastPC <= PCIn`
  - `Primed <= 1`
  - These update whether or not the entry is stored or dropped.
- Push:
  - If `cap && !Full`, write `{PCIn, DataIn}` at the write pointer and increment it.
  - If `cap && Full && !pop`, drop the entry; `DropCount` increments and saturates at all-ones.
- Pop = `RdValid && RdReady`; the read pointer increments.
- Simultaneous push and pop:
  - When `Full`: both occur, `Count` is unchanged, no drop.
  - When empty: pop is impossible (`RdValid` = 0); the push occurs.
- Pointer wrap: the low bits index storage. Empty is pointers equal. Full is low bits equal with MSBs different.
- `RdPC`/`RdData` are the storage word at the read pointer (first-word fall-through). They are don't-care when `RdValid` = 0; the bench must not check them then.
- `Clear`:
  - Resets pointers, `DropCount` and `Primed` to 0.
  - Overrides push and pop in the same cycle.
  - `LastPC` is not updated that cycle.
- Reset (`Rst` low, any time, including mid-drain):
  - Pointers, `Primed`, `DropCount` and `LastPC` go to 0.
  - Outputs: `RdValid` = 0, `Count` = 0, `Full` = 0, `DropCount` = 0.
  - `RdPC`/`RdData` are undefined; storage is not reset.
- `PCIn` = 0 after the core's reset is captured only via the priming rule: the first enabled cycle always captures.

## Timing
- Capture latency: an entry sampled at edge t is visible on `RdValid`/`RdPC`/`RdData` after edge t. Latency is one cycle from input to output.
- `Count`, `Full` and `DropCount` reflect all edges up to and including t.
- Pop at edge t: the next entry appears after edge t. Sustained throughput is 1 entry/cycle.
- No combinational path from `RdReady` to `RdValid`. No combinational path from inputs to `Full` or `Count`.
- Stall cycles (PC held by the hazard unit) produce no entries. Back-to-back PC changes produce one entry per cycle.

## Structure
- Shared package holds:
  - the default `DEPTH` and `CW`
  - the entry width constant (64)
  - field offsets: PC [63:32], data [31:0]
- One sub-module, `trace_fifo_mem`:
  - Holds the storage array, pointers and full/empty/count logic.
  - Has push/pop/clear inputs.
- The top of the block holds the capture logic (`LastPC`, `Primed`, compare) and the drop counter.

## Test plan
- **Reset priming:** `Rst` low 3 cycles, then high with `Enable`=1, `PCIn`=0, `DataIn`=0x5 held 4 cycles.
  - Exactly one entry {0x0, 0x5}.
  - `Count`=1.
- **Stall filtering:** PC sequence 0x4, 0x8, 0x8, 0x8, 0xC, with `RdReady`=0.
  - Entries 0x4, 0x8, 0xC only.
  - `Count`=3.
- **Overflow:** `DEPTH`=16; push 20 distinct PCs with `RdReady`=0.
  - `Full`=1, `Count`=16, `DropCount`=4.
  - Drained PCs are the first 16, in order.
- **Full with push and pop:** when full, assert `RdReady`=1 while a new PC arrives.
  - `Count` stays 16, `DropCount` unchanged.
  - Oldest entry leaves; new entry lands at the tail.
- **Clear and reset mid-drain:** fill 5 entries.
  - Pulse `Clear` while a PC change occurs: `Count`=0, `DropCount`=0, next enabled cycle captures.
  - Repeat with `Rst` low asynchronously between edges: `RdValid` falls immediately.
- **Enable gating:** `Enable`=0 while the PC changes 0x10 → 0x14, then `Enable`=1 with PC 0x14.
  - One entry, 0x14, captured because `LastPC` was not updated while disabled.
